// File: rtl/pipelined_logic_gate.sv
// -----------------------------------------------------------------------------
// pipelined_logic_gate
// Bitwise N-input, W-bit logic gate with per-operand inversion bubbles and a
// runtime-selected operation. The result travels through PIPE_STAGES registers
// that each carry {data, valid, illegal}. The whole pipeline advances only
// while Tick=1.
//
// Ports:
//   Clock      - design clock, rising edge
//   Reset      - synchronous active-high reset, priority over Tick
//   Tick       - clock enable; pipeline advances only when 1
//   Inputs     - packed operands, operand i = Inputs[i*WIDTH +: WIDTH]
//   Op         - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved
//   In_Valid   - qualifies Inputs/Op on the current cycle
//   Result     - registered gate result (holds last valid value)
//   Out_Valid  - Result holds a valid computed value
//   Illegal_Op - Result was computed with a reserved Op
//
// Optional build macro: GATE_STABLE_FILTER_EN adds a stability filter after
// the last stage; Result only changes after FILTER_CYCLES equal valid values.
// -----------------------------------------------------------------------------
module pipelined_logic_gate #(
   parameter int                    NUM_INPUTS    = 4,
   parameter int                    WIDTH         = 1,
   parameter logic [NUM_INPUTS-1:0] BubblesMask   = {NUM_INPUTS{1'b0}},
   parameter int                    PIPE_STAGES   = 1,
   parameter int                    FILTER_CYCLES = 2
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        Tick,
   input  logic [NUM_INPUTS*WIDTH-1:0] Inputs,
   input  logic [2:0]                  Op,
   input  logic                        In_Valid,
   output logic [WIDTH-1:0]            Result,
   output logic                        Out_Valid,
   output logic                        Illegal_Op
);

   localparam int LAST = PIPE_STAGES - 1;

   // Odd parity per bit position across all operands.
   function automatic logic [WIDTH-1:0] parity_fn(input logic [NUM_INPUTS*WIDTH-1:0] ops);
      logic [WIDTH-1:0] acc;
      acc = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
         acc = acc ^ ops[i*WIDTH +: WIDTH];
      end
      return acc;
   endfunction

   logic [NUM_INPUTS*WIDTH-1:0] real_ops_s;
   logic [WIDTH-1:0]            and_s;
   logic [WIDTH-1:0]            or_s;
   logic [WIDTH-1:0]            xor_s;
   logic [WIDTH-1:0]            func_s;
   logic                        reserved_s;

   logic [WIDTH-1:0] data_r    [PIPE_STAGES];
   logic             valid_r   [PIPE_STAGES];
   logic             illegal_r [PIPE_STAGES];

   // Apply inversion bubbles and reduce operands to AND / OR / XOR terms.
   always_comb begin
      real_ops_s = Inputs;
      and_s      = {WIDTH{1'b1}};
      or_s       = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
         real_ops_s[i*WIDTH +: WIDTH] = Inputs[i*WIDTH +: WIDTH] ^ {WIDTH{BubblesMask[i]}};
         and_s = and_s & real_ops_s[i*WIDTH +: WIDTH];
         or_s  = or_s  | real_ops_s[i*WIDTH +: WIDTH];
      end
      xor_s = parity_fn(real_ops_s);
   end

   // Operation select; reserved codes force an all-zero result.
   always_comb begin
      reserved_s = 1'b0;
      case (Op)
         3'd0:    func_s = and_s;
         3'd1:    func_s = ~and_s;
         3'd2:    func_s = or_s;
         3'd3:    func_s = ~or_s;
         3'd4:    func_s = xor_s;
         3'd5:    func_s = ~xor_s;
         default: begin
            func_s     = {WIDTH{1'b0}};
            reserved_s = 1'b1;
         end
      endcase
   end

   // Pipeline shift; an invalid slot clears valid but leaves the data register alone.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_r[k]    <= {WIDTH{1'b0}};
            valid_r[k]   <= 1'b0;
            illegal_r[k] <= 1'b0;
         end
      end else if (Tick) begin
         if (In_Valid) begin
            data_r[0] <= func_s;
         end
         valid_r[0]   <= In_Valid;
         illegal_r[0] <= In_Valid & reserved_s;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (valid_r[k-1]) begin
               data_r[k] <= data_r[k-1];
            end
            valid_r[k]   <= valid_r[k-1];
            illegal_r[k] <= valid_r[k-1] & illegal_r[k-1];
         end
      end
   end

`ifdef GATE_STABLE_FILTER_EN
   localparam logic [3:0] FILT_MAX = 4'(FILTER_CYCLES);

   logic [WIDTH-1:0] cand_r;
   logic [WIDTH-1:0] res_r;
   logic [3:0]       cnt_r;
   logic [3:0]       cnt_next_s;
   logic             ov_r;
   logic             ill_r;

   // Next stability count: saturating increment on a repeat, restart at 1 on a change.
   always_comb begin
      if (data_r[LAST] == cand_r) begin
         if (cnt_r >= FILT_MAX) begin
            cnt_next_s = FILT_MAX;
         end else begin
            cnt_next_s = cnt_r + 4'd1;
         end
      end else begin
         cnt_next_s = 4'd1;
      end
   end

   // Filter state; outputs only move once the candidate has been stable long enough.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cand_r <= {WIDTH{1'b0}};
         cnt_r  <= 4'd0;
         res_r  <= {WIDTH{1'b0}};
         ov_r   <= 1'b0;
         ill_r  <= 1'b0;
      end else if (Tick && valid_r[LAST]) begin
         cand_r <= data_r[LAST];
         cnt_r  <= cnt_next_s;
         if (cnt_next_s == FILT_MAX) begin
            res_r <= data_r[LAST];
            ov_r  <= 1'b1;
            ill_r <= illegal_r[LAST];
         end
      end
   end

   assign Result     = res_r;
   assign Out_Valid  = ov_r;
   assign Illegal_Op = ill_r;
`else
   assign Result     = data_r[LAST];
   assign Out_Valid  = valid_r[LAST];
   assign Illegal_Op = illegal_r[LAST];
`endif

endmodule

// File: tb/tb_pipelined_logic_gate.sv
// -----------------------------------------------------------------------------
// tb_pipelined_logic_gate
// Directed-vector bench. Several instances with different parameters share
// Clock/Reset/Tick/Op/In_Valid; each phase checks only the instance it targets.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipelined_logic_gate;

   logic        clock;
   logic        reset;
   logic        tick;
   logic [2:0]  op;
   logic        in_valid;
   logic [3:0]  in4;
   logic [23:0] in24;
   logic [15:0] in16;

   logic       a_res, a_ov, a_ill;
   logic [7:0] b_res;  logic b_ov, b_ill;
   logic [7:0] c_res;  logic c_ov, c_ill;
   logic [3:0] d_res;  logic d_ov, d_ill;
   logic [3:0] e_res;  logic e_ov, e_ill;

   int vec_cnt;
   int miscmp_cnt;

   // 4-input, 1-bit, single stage
   pipelined_logic_gate #(.NUM_INPUTS(4), .WIDTH(1), .BubblesMask(4'b0000), .PIPE_STAGES(1)) u_a (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in4), .Op(op), .In_Valid(in_valid),
      .Result(a_res), .Out_Valid(a_ov), .Illegal_Op(a_ill));

   // 3-input, 8-bit, no bubbles
   pipelined_logic_gate #(.NUM_INPUTS(3), .WIDTH(8), .BubblesMask(3'b000), .PIPE_STAGES(1)) u_b (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in24), .Op(op), .In_Valid(in_valid),
      .Result(b_res), .Out_Valid(b_ov), .Illegal_Op(b_ill));

   // 3-input, 8-bit, operand 0 inverted
   pipelined_logic_gate #(.NUM_INPUTS(3), .WIDTH(8), .BubblesMask(3'b001), .PIPE_STAGES(1)) u_c (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in24), .Op(op), .In_Valid(in_valid),
      .Result(c_res), .Out_Valid(c_ov), .Illegal_Op(c_ill));

   // 4-input, 4-bit, three stages
   pipelined_logic_gate #(.NUM_INPUTS(4), .WIDTH(4), .BubblesMask(4'b0000), .PIPE_STAGES(3)) u_d (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in16), .Op(op), .In_Valid(in_valid),
      .Result(d_res), .Out_Valid(d_ov), .Illegal_Op(d_ill));

   // 4-input, 4-bit, four stages
   pipelined_logic_gate #(.NUM_INPUTS(4), .WIDTH(4), .BubblesMask(4'b0000), .PIPE_STAGES(4)) u_e (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in16), .Op(op), .In_Valid(in_valid),
      .Result(e_res), .Out_Valid(e_ov), .Illegal_Op(e_ill));

`ifdef GATE_STABLE_FILTER_EN
   logic f_res, f_ov, f_ill;
   // 4-input, 1-bit, single stage, three-tick filter
   pipelined_logic_gate #(.NUM_INPUTS(4), .WIDTH(1), .BubblesMask(4'b0000), .PIPE_STAGES(1),
                          .FILTER_CYCLES(3)) u_f (
      .Clock(clock), .Reset(reset), .Tick(tick), .Inputs(in4), .Op(op), .In_Valid(in_valid),
      .Result(f_res), .Out_Valid(f_ov), .Illegal_Op(f_ill));
`endif

   // free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

`ifndef GATE_STABLE_FILTER_EN
   // stream table for the three-stage instance: tick, valid, value, exp_ov, exp_res
   logic       s_tick [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       s_val  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [3:0] s_in   [9] = '{4'h1, 4'h2, 4'h3, 4'h9, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
   logic       s_eov  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [3:0] s_eres [9] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4};
`endif

   initial begin
      vec_cnt    = 0;
      miscmp_cnt = 0;
      reset      = 1'b1;
      tick       = 1'b1;
      op         = 3'd0;
      in_valid   = 1'b0;
      in4        = 4'h0;
      in24       = 24'h0;
      in16       = 16'h0;
      step();
      check_eq("rst_a_ov",  32'(a_ov),  32'd0);
      check_eq("rst_a_res", 32'(a_res), 32'd0);
      check_eq("rst_a_ill", 32'(a_ill), 32'd0);
      check_eq("rst_b_ov",  32'(b_ov),  32'd0);
      check_eq("rst_c_ov",  32'(c_ov),  32'd0);
      check_eq("rst_d_ov",  32'(d_ov),  32'd0);
      check_eq("rst_e_ov",  32'(e_ov),  32'd0);
      check_eq("rst_cde_ill", 32'({c_ill, d_ill, e_ill}), 32'd0);
      reset = 1'b0;

`ifndef GATE_STABLE_FILTER_EN
      // NAND, single bit
      op = 3'd1; in_valid = 1'b1; in4 = 4'b1111;
      step();
      check_eq("nand_1111_res", 32'(a_res), 32'd0);
      check_eq("nand_1111_ov",  32'(a_ov),  32'd1);
      in4 = 4'b0111;
      step();
      check_eq("nand_0111_res", 32'(a_res), 32'd1);

      // 8-bit ops over F0, CC, AA (operand 0 = F0)
      in24 = {8'hAA, 8'hCC, 8'hF0};
      op = 3'd4; step();
      check_eq("xor_res",      32'(b_res), 32'h96);
      check_eq("xor_bub_res",  32'(c_res), 32'h69);
      check_eq("xor_ill",      32'(b_ill), 32'd0);
      op = 3'd0; step();
      check_eq("and_res",      32'(b_res), 32'h80);
      check_eq("and_bub_res",  32'(c_res), 32'h08);
      op = 3'd2; step();
      check_eq("or_res",       32'(b_res), 32'hFE);
      check_eq("or_bub_res",   32'(c_res), 32'hEF);
      op = 3'd1; step();
      check_eq("nand8_res",    32'(b_res), 32'h7F);
      op = 3'd3; step();
      check_eq("nor8_res",     32'(b_res), 32'h01);
      op = 3'd5; step();
      check_eq("xnor8_res",    32'(b_res), 32'h69);

      // reserved ops
      in4 = 4'b1111;
      op = 3'd6; step();
      check_eq("op6_res", 32'(a_res), 32'd0);
      check_eq("op6_ill", 32'(a_ill), 32'd1);
      check_eq("op6_ov",  32'(a_ov),  32'd1);
      op = 3'd7; step();
      check_eq("op7_ill", 32'(a_ill), 32'd1);
      op = 3'd0; step();
      check_eq("op0_res", 32'(a_res), 32'd1);
      check_eq("op0_ill", 32'(a_ill), 32'd0);

      // bubble keeps data, clears valid
      in_valid = 1'b0; step();
      check_eq("bubble_ov",  32'(a_ov),  32'd0);
      check_eq("bubble_res", 32'(a_res), 32'd1);
      check_eq("bubble_ill", 32'(a_ill), 32'd0);
      // stalled input is dropped
      tick = 1'b0; in_valid = 1'b1; op = 3'd2; in4 = 4'b0000; step();
      check_eq("stall_ov",  32'(a_ov),  32'd0);
      check_eq("stall_res", 32'(a_res), 32'd1);
      tick = 1'b1; step();
      check_eq("resume_ov",  32'(a_ov),  32'd1);
      check_eq("resume_res", 32'(a_res), 32'd0);

      // three-stage stream with a two-cycle stall
      reset = 1'b1; in_valid = 1'b0; step(); reset = 1'b0;
      op = 3'd2;
      for (int i = 0; i < 9; i++) begin
         tick = s_tick[i]; in_valid = s_val[i]; in16 = {12'h000, s_in[i]};
         step();
         check_eq($sformatf("stream%0d_ov", i),  32'(d_ov),  32'(s_eov[i]));
         check_eq($sformatf("stream%0d_res", i), 32'(d_res), 32'(s_eres[i]));
      end
      tick = 1'b1;

      // reset with a full four-stage pipeline
      reset = 1'b1; in_valid = 1'b0; step(); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in16 = {12'h000, 4'(i + 5)};
         step();
         check_eq($sformatf("fill%0d_ov", i), 32'(e_ov), (i == 3) ? 32'd1 : 32'd0);
      end
      check_eq("fill_res", 32'(e_res), 32'h5);
      reset = 1'b1; step(); reset = 1'b0;
      check_eq("midrst_res", 32'(e_res), 32'd0);
      check_eq("midrst_ov",  32'(e_ov),  32'd0);
      check_eq("midrst_ill", 32'(e_ill), 32'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq($sformatf("drain%0d_ov", i),  32'(e_ov),  32'd0);
         check_eq($sformatf("drain%0d_res", i), 32'(e_res), 32'd0);
      end
`else
      // filter: OR results 1,0,1,1,1 then idle; filter lags the stage by one tick
      op = 3'd2; in_valid = 1'b1;
      in4 = 4'b0001; step(); check_eq("flt0_res", 32'(f_res), 32'd0);
      in4 = 4'b0000; step(); check_eq("flt1_res", 32'(f_res), 32'd0);
      in4 = 4'b0100; step(); check_eq("flt2_res", 32'(f_res), 32'd0);
      in4 = 4'b1000; step(); check_eq("flt3_res", 32'(f_res), 32'd0);
      in4 = 4'b0010; step(); check_eq("flt4_res", 32'(f_res), 32'd0);
      check_eq("flt4_ov", 32'(f_ov), 32'd0);
      in_valid = 1'b0; step();
      check_eq("flt5_res", 32'(f_res), 32'd1);
      check_eq("flt5_ov",  32'(f_ov),  32'd1);
      check_eq("flt5_ill", 32'(f_ill), 32'd0);
      step();
      check_eq("flt6_ov",  32'(f_ov),  32'd1);
      check_eq("flt6_res", 32'(f_res), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
